// File: rtl/stk_pipe_arb_if.sv
// Shared types and the handshake bundle between request engines, the arbiter and the LK/WRBK stages.
// The packages live here so they are compiled ahead of every user of the bundle.
package cfg_pkg;
   localparam int ENGS_N = 4;
endpackage

package stk_pkg;
   typedef enum logic [1:0] {
      NOP  = 2'd0,
      PUSH = 2'd1,
      POP  = 2'd2,
      INV  = 2'd3
   } opcode_t;

   localparam int ENGID_W = (cfg_pkg::ENGS_N > 1) ? $clog2(cfg_pkg::ENGS_N) : 1;
   typedef logic [ENGID_W-1:0] engid_t;
endpackage

interface stk_pipe_arb_if #(
   parameter int ENGS_N = cfg_pkg::ENGS_N
);
   logic [ENGS_N-1:0]                   i_req_vld;
   stk_pkg::opcode_t [ENGS_N-1:0]       i_req_opcode;
   logic [ENGS_N-1:0][127:0]            i_req_dat;
   logic [ENGS_N-1:0]                   o_req_rdy;

   logic                                o_lk_vld_r;
   stk_pkg::engid_t                     o_lk_engid_r;
   stk_pkg::opcode_t                    o_lk_opcode_r;
   logic                                o_lk_dat_vld_r;
   logic [127:0]                        o_lk_dat_r;

   logic                                i_wrbk_uc_vld_r;
   stk_pkg::engid_t                     i_wrbk_uc_engid_r;
   logic                                i_wrbk_uc_set_empty_r;
   logic                                i_wrbk_uc_clr_empty_r;

   logic                                o_err_vld_r;
   stk_pkg::engid_t                     o_err_engid_r;

   logic [ENGS_N-1:0]                   o_busy_r;
   logic [ENGS_N-1:0]                   o_empty_r;
   logic [3:0]                          o_credits_r;

   // arbiter side
   modport slave (
      input  i_req_vld, i_req_opcode, i_req_dat,
      output o_req_rdy,
      output o_lk_vld_r, o_lk_engid_r, o_lk_opcode_r, o_lk_dat_vld_r, o_lk_dat_r,
      input  i_wrbk_uc_vld_r, i_wrbk_uc_engid_r, i_wrbk_uc_set_empty_r, i_wrbk_uc_clr_empty_r,
      output o_err_vld_r, o_err_engid_r,
      output o_busy_r, o_empty_r, o_credits_r
   );

   // engines / pipeline side
   modport master (
      output i_req_vld, i_req_opcode, i_req_dat,
      input  o_req_rdy,
      input  o_lk_vld_r, o_lk_engid_r, o_lk_opcode_r, o_lk_dat_vld_r, o_lk_dat_r,
      output i_wrbk_uc_vld_r, i_wrbk_uc_engid_r, i_wrbk_uc_set_empty_r, i_wrbk_uc_clr_empty_r,
      input  o_err_vld_r, o_err_engid_r,
      input  o_busy_r, o_empty_r, o_credits_r
   );
endinterface

// File: rtl/stk_pipe_arb.sv
// Round-robin arbiter feeding stack commands into the LK stage, with per-engine hazard lock,
// credit flow control towards WRBK and early rejection of pops on an empty stack.
module stk_pipe_arb #(
   parameter int ENGS_N    = cfg_pkg::ENGS_N,
   parameter int CREDITS_N = 4
) (
   input  logic           clk,
   input  logic           rst,
   stk_pipe_arb_if.slave  bus
);
   import stk_pkg::*;

   localparam logic [3:0] CRED_MAX = 4'(CREDITS_N);

   logic [ENGS_N-1:0]  busy_r;
   logic [ENGS_N-1:0]  empty_r;
   logic [3:0]         credits_r;
   engid_t             rr_ptr_r;

   logic               lk_vld_r;
   engid_t             lk_engid_r;
   opcode_t            lk_opcode_r;
   logic               lk_dat_vld_r;
   logic [127:0]       lk_dat_r;
   logic               err_vld_r;
   engid_t             err_engid_r;

   logic [ENGS_N-1:0]  cand;
   logic [ENGS_N-1:0]  reject;
   logic [ENGS_N-1:0]  elig;
   logic               gnt;
   engid_t             gnt_id;
   logic [ENGS_N-1:0]  gnt_oh;
   logic               gnt_issue;
   logic               gnt_reject;
   logic               wb;

   logic [ENGS_N-1:0]  busy_nxt;
   logic [ENGS_N-1:0]  empty_nxt;
   logic [3:0]         credits_nxt;

   assign wb = bus.i_wrbk_uc_vld_r;

   // Rejects bypass the credit check: they never reach LK, so they hold no credit.
   always_comb begin
      cand   = '0;
      reject = '0;
      elig   = '0;
      for (int e = 0; e < ENGS_N; e++) begin
         cand[e]   = bus.i_req_vld[e] && (bus.i_req_opcode[e] != NOP) && !busy_r[e];
         reject[e] = cand[e] && (bus.i_req_opcode[e] == POP) && empty_r[e];
         elig[e]   = reject[e] || (cand[e] && (credits_r != 4'd0));
      end
   end

   always_comb begin
      int idx;
      idx    = 0;
      gnt    = 1'b0;
      gnt_id = '0;
      for (int k = 0; k < ENGS_N; k++) begin
         idx = int'(rr_ptr_r) + k;
         if (idx >= ENGS_N) begin
            idx = idx - ENGS_N;
         end
         if (!gnt && elig[idx]) begin
            gnt    = 1'b1;
            gnt_id = engid_t'(idx);
         end
      end
      if (rst) begin
         gnt = 1'b0;
      end
   end

   always_comb begin
      gnt_oh = '0;
      if (gnt) begin
         gnt_oh[gnt_id] = 1'b1;
      end
      gnt_issue  = gnt && !reject[gnt_id];
      gnt_reject = gnt && reject[gnt_id];
   end

   assign bus.o_req_rdy = gnt_oh;

   // Writeback clears first so a fresh grant on the same engine keeps it busy.
   always_comb begin
      busy_nxt    = busy_r;
      empty_nxt   = empty_r;
      credits_nxt = credits_r;
      if (wb) begin
         busy_nxt[bus.i_wrbk_uc_engid_r] = 1'b0;
         if (bus.i_wrbk_uc_set_empty_r) begin
            empty_nxt[bus.i_wrbk_uc_engid_r] = 1'b1;
         end else if (bus.i_wrbk_uc_clr_empty_r) begin
            empty_nxt[bus.i_wrbk_uc_engid_r] = 1'b0;
         end
      end
      if (gnt_issue) begin
         busy_nxt[gnt_id] = 1'b1;
      end
      if (wb && !gnt_issue) begin
         credits_nxt = (credits_r >= CRED_MAX) ? CRED_MAX : credits_r + 4'd1;
      end else if (!wb && gnt_issue) begin
         credits_nxt = (credits_r == 4'd0) ? 4'd0 : credits_r - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r       <= '0;
         empty_r      <= '1;
         credits_r    <= CRED_MAX;
         rr_ptr_r     <= '0;
         lk_vld_r     <= 1'b0;
         lk_engid_r   <= '0;
         lk_opcode_r  <= NOP;
         lk_dat_vld_r <= 1'b0;
         lk_dat_r     <= '0;
         err_vld_r    <= 1'b0;
         err_engid_r  <= '0;
      end else begin
         busy_r    <= busy_nxt;
         empty_r   <= empty_nxt;
         credits_r <= credits_nxt;
         if (gnt) begin
            rr_ptr_r <= (int'(gnt_id) == ENGS_N - 1) ? '0 : engid_t'(gnt_id + 1'b1);
         end

         lk_vld_r <= gnt_issue;
         if (gnt_issue) begin
            lk_engid_r   <= gnt_id;
            lk_opcode_r  <= bus.i_req_opcode[gnt_id];
            lk_dat_vld_r <= (bus.i_req_opcode[gnt_id] == PUSH);
            lk_dat_r     <= (bus.i_req_opcode[gnt_id] == PUSH) ? bus.i_req_dat[gnt_id] : '0;
         end else begin
            lk_opcode_r  <= NOP;
            lk_dat_vld_r <= 1'b0;
         end

         err_vld_r <= gnt_reject;
         if (gnt_reject) begin
            err_engid_r <= gnt_id;
         end
      end
   end

   assign bus.o_lk_vld_r     = lk_vld_r;
   assign bus.o_lk_engid_r   = lk_engid_r;
   assign bus.o_lk_opcode_r  = lk_opcode_r;
   assign bus.o_lk_dat_vld_r = lk_dat_vld_r;
   assign bus.o_lk_dat_r     = lk_dat_r;
   assign bus.o_err_vld_r    = err_vld_r;
   assign bus.o_err_engid_r  = err_engid_r;
   assign bus.o_busy_r       = busy_r;
   assign bus.o_empty_r      = empty_r;
   assign bus.o_credits_r    = credits_r;

`ifndef SYNTHESIS
   // A writeback must return a credit that was actually taken, for an engine that is in flight.
   a_wb_credit_ovf : assert property (@(posedge clk) disable iff (rst)
      bus.i_wrbk_uc_vld_r |-> (credits_r != CRED_MAX));
   a_wb_not_busy : assert property (@(posedge clk) disable iff (rst)
      bus.i_wrbk_uc_vld_r |-> busy_r[bus.i_wrbk_uc_engid_r]);
   a_rdy_onehot : assert property (@(posedge clk) $onehot0(bus.o_req_rdy));
`endif
endmodule

// File: tb/tb_stk_pipe_arb.sv
// Randomized bench for stk_pipe_arb: a stack-level reference model predicts grants, and a
// scoreboard queue is drained by an independent monitor watching the LK and error outputs.
module tb_stk_pipe_arb;
   import stk_pkg::*;

   localparam int N    = cfg_pkg::ENGS_N;
   localparam int CRED = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   stk_pipe_arb_if #(.ENGS_N(N)) bus ();
   stk_pipe_arb_if #(.ENGS_N(N)) bus2 ();

   stk_pipe_arb #(.ENGS_N(N), .CREDITS_N(CRED)) dut  (.clk(clk), .rst(rst), .bus(bus));
   stk_pipe_arb #(.ENGS_N(N), .CREDITS_N(2))    dut2 (.clk(clk), .rst(rst), .bus(bus2));

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit           is_err;
      int           eng;
      opcode_t      op;
      logic [127:0] dat;
   } exp_t;
   typedef struct {
      int      eng;
      opcode_t op;
      int      due;
   } infl_t;

   exp_t  exp_q[$];
   infl_t infl_q[$];

   // reference model: stack depth per engine, busy/empty shadows, free credits, next-in-line pointer
   bit           busy_m[N];
   bit           empty_m[N];
   int           depth_m[N];
   int           credits_m;
   int           rr_m;
   int           cyc;

   bit           vld_s[N];
   opcode_t      op_s[N];
   logic [127:0] dat_s[N];
   bit           auto_wb;
   int           wb_pct;
   int           wb_dmin;
   int           wb_dmax;

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic opcode_t rand_op();
      int r;
      r = $urandom_range(99);
      if (r < 20)      return NOP;
      else if (r < 60) return PUSH;
      else if (r < 90) return POP;
      else             return INV;
   endfunction

   task automatic model_reset();
      for (int e = 0; e < N; e++) begin
         busy_m[e]  = 1'b0;
         empty_m[e] = 1'b1;
         depth_m[e] = 0;
      end
      credits_m = CRED;
      rr_m      = 0;
      infl_q.delete();
      exp_q.delete();
   endtask

   task automatic clear_req();
      for (int e = 0; e < N; e++) begin
         vld_s[e] = 1'b0;
         op_s[e]  = NOP;
         dat_s[e] = '0;
      end
   endtask

   // one cycle on the main DUT: drive at negedge, check and predict, advance to next negedge
   task automatic step();
      int           g;
      int           e;
      int           wi;
      bit           rej;
      bit           wb_v;
      int           wb_e;
      bit           wb_s;
      bit           wb_c;
      logic [N-1:0] er;
      logic [N-1:0] bv;
      logic [N-1:0] ev;
      for (int i = 0; i < N; i++) begin
         bus.i_req_vld[i]    = vld_s[i];
         bus.i_req_opcode[i] = op_s[i];
         bus.i_req_dat[i]    = dat_s[i];
      end
      wb_v = 1'b0; wb_e = 0; wb_s = 1'b0; wb_c = 1'b0; wi = -1;
      if (auto_wb) begin
         for (int i = 0; i < infl_q.size(); i++) begin
            if (wi < 0 && infl_q[i].due <= cyc) wi = i;
         end
      end
      if (wi >= 0 && $urandom_range(99) < wb_pct) begin
         wb_v = 1'b1;
         wb_e = infl_q[wi].eng;
         case (infl_q[wi].op)
            PUSH: begin depth_m[wb_e]++; wb_c = 1'b1; end
            POP:  begin depth_m[wb_e]--; wb_s = (depth_m[wb_e] == 0); end
            default: begin depth_m[wb_e] = 0; wb_s = 1'b1; wb_c = 1'($urandom_range(1)); end
         endcase
         infl_q.delete(wi);
      end
      bus.i_wrbk_uc_vld_r       = wb_v;
      bus.i_wrbk_uc_engid_r     = engid_t'(wb_e);
      bus.i_wrbk_uc_set_empty_r = wb_s;
      bus.i_wrbk_uc_clr_empty_r = wb_c;
      #1;
      g = -1;
      for (int k = 0; k < N; k++) begin
         e = (rr_m + k) % N;
         if (g < 0 && vld_s[e] && op_s[e] != NOP && !busy_m[e] &&
             ((op_s[e] == POP && empty_m[e]) || credits_m > 0)) g = e;
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      for (int i = 0; i < N; i++) begin
         bv[i] = busy_m[i];
         ev[i] = empty_m[i];
      end
      chk("req_rdy", bus.o_req_rdy, er);
      chk("busy", bus.o_busy_r, bv);
      chk("empty", bus.o_empty_r, ev);
      chk("credits", bus.o_credits_r, 128'(credits_m));
      if (wb_v) begin
         busy_m[wb_e] = 1'b0;
         if (wb_s)      empty_m[wb_e] = 1'b1;
         else if (wb_c) empty_m[wb_e] = 1'b0;
         credits_m++;
         if (credits_m > CRED) credits_m = CRED;
      end
      if (g >= 0) begin
         rej = (op_s[g] == POP) && empty_m[g] && !(wb_v && wb_e == g);
         rej = (op_s[g] == POP) && ev[g];
         exp_q.push_back('{rej, g, op_s[g], (op_s[g] == PUSH) ? dat_s[g] : 128'h0});
         if (!rej) begin
            busy_m[g] = 1'b1;
            credits_m--;
            infl_q.push_back('{g, op_s[g], cyc + $urandom_range(wb_dmax, wb_dmin)});
         end
         rr_m = (g + 1) % N;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic drain();
      clear_req();
      auto_wb = 1'b1;
      wb_pct  = 100;
      for (int i = 0; i < 80 && infl_q.size() > 0; i++) step();
      chk("drain_timeout", 128'(infl_q.size()), 0);
      step();
   endtask

   task automatic do_reset(bit wb_during);
      rst = 1'b1;
      for (int e = 0; e < N; e++) begin
         bus.i_req_vld[e]    = 1'b1;
         bus.i_req_opcode[e] = PUSH;
         bus.i_req_dat[e]    = 128'(e + 1);
      end
      bus.i_wrbk_uc_vld_r       = wb_during;
      bus.i_wrbk_uc_engid_r     = '0;
      bus.i_wrbk_uc_set_empty_r = 1'b0;
      bus.i_wrbk_uc_clr_empty_r = wb_during;
      #1;
      chk("rdy_in_reset", bus.o_req_rdy, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.i_req_vld             = '0;
      bus.i_wrbk_uc_vld_r       = 1'b0;
      bus.i_wrbk_uc_clr_empty_r = 1'b0;
      clear_req();
      model_reset();
      cyc++;
   endtask

   task automatic step2(string tag, logic [N-1:0] exp_rdy);
      #1;
      chk({tag, "_rdy"}, bus2.o_req_rdy, exp_rdy);
      @(posedge clk);
      @(negedge clk);
   endtask

   // monitor: pops the scoreboard whenever the DUT presents a command or a rejection
   initial begin
      exp_t         ex;
      int           last_eng;
      logic [127:0] last_dat;
      int           last_err;
      last_eng = 0; last_dat = '0; last_err = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            last_eng = 0; last_dat = '0; last_err = 0;
         end else if (bus.o_lk_vld_r || bus.o_err_vld_r) begin
            chk("lk_err_exclusive", 128'(bus.o_lk_vld_r & bus.o_err_vld_r), 0);
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               ex = exp_q.pop_front();
               if (ex.is_err) begin
                  chk("err_vld", bus.o_err_vld_r, 1);
                  chk("err_lk_vld", bus.o_lk_vld_r, 0);
                  chk("err_engid", bus.o_err_engid_r, 128'(ex.eng));
                  last_err = ex.eng;
               end else begin
                  chk("lk_vld", bus.o_lk_vld_r, 1);
                  chk("lk_engid", bus.o_lk_engid_r, 128'(ex.eng));
                  chk("lk_opcode", bus.o_lk_opcode_r, ex.op);
                  chk("lk_dat_vld", bus.o_lk_dat_vld_r, 128'(ex.op == PUSH));
                  chk("lk_dat", bus.o_lk_dat_r, ex.dat);
                  last_eng = ex.eng;
                  last_dat = ex.dat;
               end
            end
         end else begin
            chk("missing_output", 128'(exp_q.size()), 0);
            chk("idle_opcode", bus.o_lk_opcode_r, NOP);
            chk("idle_dat_vld", bus.o_lk_dat_vld_r, 0);
            chk("idle_engid_hold", bus.o_lk_engid_r, 128'(last_eng));
            chk("idle_dat_hold", bus.o_lk_dat_r, last_dat);
            chk("idle_err_engid_hold", bus.o_err_engid_r, 128'(last_err));
         end
      end
   end

   initial begin
      auto_wb = 1'b0; wb_pct = 100; wb_dmin = 2; wb_dmax = 2; cyc = 0;
      clear_req();
      bus2.i_req_vld = '0;
      bus2.i_req_opcode = '{default: NOP};
      bus2.i_req_dat = '0;
      bus2.i_wrbk_uc_vld_r = 1'b0;
      bus2.i_wrbk_uc_engid_r = '0;
      bus2.i_wrbk_uc_set_empty_r = 1'b0;
      bus2.i_wrbk_uc_clr_empty_r = 1'b0;
      @(negedge clk);
      do_reset(1'b0);

      chk("rst_lk_vld", bus.o_lk_vld_r, 0);
      chk("rst_lk_opcode", bus.o_lk_opcode_r, NOP);
      chk("rst_lk_engid", bus.o_lk_engid_r, 0);
      chk("rst_lk_dat", {bus.o_lk_dat_vld_r, bus.o_lk_dat_r}, 0);
      chk("rst_err", {bus.o_err_vld_r, bus.o_err_engid_r}, 0);
      chk("rst_busy", bus.o_busy_r, 0);
      chk("rst_empty", bus.o_empty_r, {N{1'b1}});
      chk("rst_credits", bus.o_credits_r, CRED);

      // two-credit instance: exhaustion, reject without credit, single regrant, net-zero credit
      for (int e = 0; e < N; e++) begin
         bus2.i_req_vld[e]    = 1'b1;
         bus2.i_req_opcode[e] = PUSH;
         bus2.i_req_dat[e]    = 128'(e);
      end
      chk("c2_cred_init", bus2.o_credits_r, 2);
      step2("c2_g0", 4'b0001);
      step2("c2_g1", 4'b0010);
      chk("c2_cred_zero", bus2.o_credits_r, 0);
      bus2.i_req_opcode[2] = POP;
      step2("c2_reject", 4'b0100);
      bus2.i_req_opcode[2] = PUSH;
      chk("c2_err_vld", bus2.o_err_vld_r, 1);
      chk("c2_err_engid", bus2.o_err_engid_r, 2);
      chk("c2_err_no_lk", bus2.o_lk_vld_r, 0);
      chk("c2_reject_credits", bus2.o_credits_r, 0);
      bus2.i_wrbk_uc_vld_r = 1'b1; bus2.i_wrbk_uc_engid_r = 0;
      step2("c2_wb_nogrant", 4'b0000);
      bus2.i_wrbk_uc_vld_r = 1'b0;
      chk("c2_cred_back", bus2.o_credits_r, 1);
      step2("c2_one_more", 4'b1000);
      chk("c2_cred_again_zero", bus2.o_credits_r, 0);
      chk("c2_lk_engid3", bus2.o_lk_engid_r, 3);
      bus2.i_wrbk_uc_vld_r = 1'b1; bus2.i_wrbk_uc_engid_r = 1;
      step2("c2_exhausted", 4'b0000);
      bus2.i_wrbk_uc_engid_r = 3;
      chk("c2_cred_one", bus2.o_credits_r, 1);
      step2("c2_gnt_with_wb", 4'b0001);
      bus2.i_wrbk_uc_vld_r = 1'b0;
      bus2.i_req_vld = '0;
      chk("c2_net_credit", bus2.o_credits_r, 1);
      chk("c2_busy", bus2.o_busy_r, 4'b0001);

      // single push, then its writeback two cycles later
      vld_s[0] = 1'b1; op_s[0] = PUSH; dat_s[0] = 128'hA5;
      step();
      clear_req();
      chk("push_credits", bus.o_credits_r, CRED - 1);
      chk("push_busy", bus.o_busy_r, 1);
      chk("push_lk_dat", bus.o_lk_dat_r, 128'hA5);
      drain();

      // pop on an empty stack is rejected without taking a credit
      vld_s[2] = 1'b1; op_s[2] = POP;
      step();
      clear_req();
      chk("pop_empty_credits", bus.o_credits_r, CRED);
      step();

      // all engines pushing continuously with fixed writeback latency
      for (int i = 0; i < 24; i++) begin
         for (int e = 0; e < N; e++) begin
            vld_s[e] = 1'b1; op_s[e] = PUSH; dat_s[e] = {$urandom, $urandom, $urandom, $urandom};
         end
         auto_wb = 1'b1;
         step();
      end
      drain();

      // random traffic with variable writeback latency
      wb_dmin = 1; wb_dmax = 6;
      for (int i = 0; i < 500; i++) begin
         for (int e = 0; e < N; e++) begin
            vld_s[e] = ($urandom_range(99) < 70);
            op_s[e]  = rand_op();
            dat_s[e] = {$urandom, $urandom, $urandom, $urandom};
         end
         auto_wb = 1'b1; wb_pct = 60;
         step();
      end
      drain();

      // reset with three commands in flight and a writeback during the reset cycle
      auto_wb = 1'b0;
      for (int e = 0; e < 3; e++) begin
         vld_s[e] = 1'b1; op_s[e] = PUSH; dat_s[e] = 128'(e + 16);
      end
      for (int i = 0; i < 3; i++) step();
      chk("inflight_before_reset", bus.o_busy_r, 4'b0111);
      do_reset(1'b1);
      chk("mid_rst_lk_vld", bus.o_lk_vld_r, 0);
      chk("mid_rst_busy", bus.o_busy_r, 0);
      chk("mid_rst_empty", bus.o_empty_r, {N{1'b1}});
      chk("mid_rst_credits", bus.o_credits_r, CRED);
      step();
      chk("post_rst_lk_vld", bus.o_lk_vld_r, 0);

      for (int i = 0; i < 200; i++) begin
         for (int e = 0; e < N; e++) begin
            vld_s[e] = ($urandom_range(99) < 80);
            op_s[e]  = rand_op();
            dat_s[e] = {$urandom, $urandom, $urandom, $urandom};
         end
         auto_wb = 1'b1; wb_pct = 50;
         step();
      end
      drain();
      step();
      chk("scoreboard_empty", 128'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/stk_pipe_arb.md
STK_PIPE_ARB -- requirements
Module: stk_pipe_arb

Parameters
REQ-001 SHALL have parameter ENGS_N, default cfg_pkg::ENGS_N, the number of requesting engines (at least 2).
REQ-002 SHALL have parameter CREDITS_N, default 4, the maximum number of commands in flight between the LK and WRBK stages (1..15).

Interface
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 i_req_vld  in  ENGS_N  per-engine request valid.
REQ-006 i_req_opcode  in  ENGS_N x stk_pkg::opcode_t  per-engine opcode: NOP, PUSH, POP or INV.
REQ-007 i_req_dat  in  ENGS_N x 128  per-engine push data.
REQ-008 o_req_rdy  out  ENGS_N  per-engine accept; combinational, one-hot or zero.
REQ-009 o_lk_vld_r, o_lk_engid_r (stk_pkg::engid_t), o_lk_opcode_r (opcode_t), o_lk_dat_vld_r (1), o_lk_dat_r (128)  out  registered command into the LK stage.
REQ-010 i_wrbk_uc_vld_r  in  1, i_wrbk_uc_engid_r  in  engid_t, i_wrbk_uc_set_empty_r  in  1, i_wrbk_uc_clr_empty_r  in  1  writeback completion.
REQ-011 o_err_vld_r  out  1, o_err_engid_r  out  engid_t  registered pop-on-empty rejection.
REQ-012 o_busy_r  out  ENGS_N  per-engine in-flight flag.
REQ-013 o_empty_r  out  ENGS_N  per-engine empty shadow.
REQ-014 o_credits_r  out  4  free credit count.

Function
REQ-015 A request from engine e SHALL be a candidate when i_req_vld[e]=1, i_req_opcode[e]!=NOP and busy[e]=0; NOP requests SHALL never be accepted.
REQ-016 A candidate SHALL be "reject-class" if it is a POP and empty[e]=1; it SHALL be "issue-class" otherwise.
REQ-017 An issue-class candidate SHALL be eligible only when credits!=0; a reject-class candidate SHALL be eligible regardless of credits.
REQ-018 Arbitration SHALL be round-robin: scan eligible engines starting from rr_ptr, grant the first, and assert o_req_rdy for that engine only, in the same cycle.
REQ-019 On any grant, rr_ptr SHALL update to (granted engine + 1) mod ENGS_N; with no grant, rr_ptr SHALL hold.
REQ-020 An issue-class grant SHALL, in the next cycle, drive o_lk_vld_r=1 with the engid and opcode, o_lk_dat_vld_r=(opcode==PUSH), and o_lk_dat_r = data if PUSH else 0.
  - Same edge: busy[e] set, credits decremented.
REQ-021 A reject-class grant SHALL, in the next cycle, drive o_err_vld_r=1 with o_err_engid_r=e, leaving o_lk_vld_r=0, busy and credits unchanged.
REQ-022 With no grant, o_lk_vld_r=0, o_lk_opcode_r=NOP, o_lk_dat_vld_r=0 and o_err_vld_r=0; engid and data SHALL hold.
  - Issue latency: 1 cycle.
  - Throughput: at most 1 grant per cycle.
REQ-023 i_wrbk_uc_vld_r=1 SHALL clear busy[engid] and increment credits at that edge.
  - The freed engine SHALL become eligible from the following cycle, since arbitration uses registered busy.
REQ-024 A simultaneous grant and writeback SHALL leave credits net unchanged.
  - Where both address the same engine, the set from the new grant wins (the engine can only be granted if already not busy).
REQ-025 A writeback with set_empty SHALL set empty[engid], one with clr_empty SHALL clear it, and set_empty SHALL take priority if both are asserted.
REQ-026 Credits SHALL saturate at CREDITS_N and at 0.
  - A writeback at CREDITS_N, or for a non-busy engine, is a protocol error and SHALL be flagged by a simulation assertion.
REQ-027 At most one command per engine SHALL be in flight (hazard protection for head/tail pointer tables).

Reset
REQ-028 When rst=1, at the clock edge:
  - o_lk_vld_r=0, o_lk_opcode_r=NOP, o_lk_engid_r=0, o_lk_dat_vld_r=0, o_lk_dat_r=0
  - o_err_vld_r=0, o_err_engid_r=0
  - busy='0, empty='1, credits=CREDITS_N, rr_ptr=0
REQ-029 While rst=1, o_req_rdy SHALL be 0; a reset mid-flight SHALL discard all busy state and ignore writebacks that arrive during the reset cycle.

Verification
REQ-030 After reset, engine 0 PUSH 0xA5 -> rdy[0]=1; next cycle lk_vld=1, engid=0, PUSH, dat_vld=1, dat=0xA5; busy[0]=1, credits=3.
REQ-031 All four engines request PUSH continuously, with writebacks returning 2 cycles after issue -> grants in order 0,1,2,3,0,...; no engine is granted while busy.
REQ-032 Engine 2 POP with empty[2]=1 -> rdy[2]=1; next cycle err_vld=1, err_engid=2, lk_vld=0; credits unchanged.
REQ-033 CREDITS_N=2 with no writebacks -> two grants, then rdy=0 for issue-class requests; a pop-on-empty is still rejected; one writeback -> exactly one more grant.
REQ-034 Grant and writeback in the same cycle at credits=1 -> credits stays 1.
REQ-035 rst asserted with 3 commands in flight -> credits=CREDITS_N, busy=0, empty='1, no lk_vld the next cycle.
